// File: rtl/sigma_launch_buffer.sv
// Two-entry ping-pong buffer carrying error-locator polynomials from KES into Chien search.
// Each sigma is launched with a one-cycle start pulse and held stable until Chien reports done.
module sigma_launch_buffer #(
    parameter int W     = 10,
    parameter int T     = 11,
    parameter int TAG_W = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 kes_valid_i,
    output logic                 kes_ready_o,
    input  logic [(T+1)*W-1:0]   kes_sigma_i,
    input  logic [TAG_W-1:0]     kes_tag_i,
    input  logic                 flush_i,
    output logic                 start_o,
    output logic                 sigma_valid_o,
    output logic [(T+1)*W-1:0]   sigma_low_o,
    output logic [TAG_W-1:0]     tag_o,
    input  logic                 chien_done_i,
    output logic                 busy_o,
    output logic [1:0]           occupancy_o,
    output logic                 proto_err_o
);

    localparam int SW = (T + 1) * W;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [1:0]         r_count;
    logic               r_wr_ptr;
    logic               r_rd_ptr;
    logic               r_proto_err;
    logic [SW-1:0]      r_sigma [2];
    logic [TAG_W-1:0]   r_tag   [2];
    logic               w_push;
    logic               w_pop;

    assign kes_ready_o = (r_count != 2'd2) && !flush_i;
    assign w_push      = kes_valid_i && kes_ready_o;
    assign w_pop       = (r_state == S_WAIT) && chien_done_i && !flush_i;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (r_count != 2'd0) w_state_nxt = S_LAUNCH;
            S_LAUNCH: w_state_nxt = S_WAIT;
            S_WAIT:   if (chien_done_i) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
        if (flush_i) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_count     <= 2'd0;
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            // A done outside WAIT is a Chien protocol slip; flush masks it.
            r_proto_err <= chien_done_i && !flush_i && (r_state != S_WAIT);
            if (flush_i) begin
                r_count  <= 2'd0;
                r_wr_ptr <= 1'b0;
                r_rd_ptr <= 1'b0;
            end else begin
                if (w_push) r_wr_ptr <= ~r_wr_ptr;
                if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 2'd1;
                    2'b01:   r_count <= r_count - 2'd1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Storage is data only; its contents are never observed while count is zero.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_sigma[r_wr_ptr] <= kes_sigma_i;
            r_tag[r_wr_ptr]   <= kes_tag_i;
        end
    end

    assign start_o       = (r_state == S_LAUNCH);
    assign sigma_valid_o = (r_state == S_LAUNCH);
    assign busy_o        = (r_state == S_WAIT);
    assign occupancy_o   = r_count;
    assign proto_err_o   = r_proto_err;
    assign sigma_low_o   = (r_count != 2'd0) ? r_sigma[r_rd_ptr] : '0;
    assign tag_o         = (r_count != 2'd0) ? r_tag[r_rd_ptr]   : '0;

    // Lambda0 of a valid locator polynomial is never zero.
    always @(posedge clk_i) begin
        if (rst_ni && start_o)
            assert (sigma_low_o[W-1:0] != '0)
            else $warning("sigma_launch_buffer: launched sigma has lambda0 == 0");
    end

endmodule

// File: tb/tb_sigma_launch_buffer.sv
// Randomized and directed bench for sigma_launch_buffer against a queue-based reference model.
module tb_sigma_launch_buffer;

    localparam int W     = 10;
    localparam int T     = 11;
    localparam int TAG_W = 4;
    localparam int SW    = (T + 1) * W;

    logic              clk;
    logic              rst_n;
    logic              kes_valid;
    logic              kes_ready;
    logic [SW-1:0]     kes_sigma;
    logic [TAG_W-1:0]  kes_tag;
    logic              flush;
    logic              start;
    logic              sigma_valid;
    logic [SW-1:0]     sigma_low;
    logic [TAG_W-1:0]  tag;
    logic              chien_done;
    logic              busy;
    logic [1:0]        occupancy;
    logic              proto_err;

    int n_tests = 0;
    int n_fail  = 0;

    sigma_launch_buffer #(.W(W), .T(T), .TAG_W(TAG_W)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .kes_valid_i   (kes_valid),
        .kes_ready_o   (kes_ready),
        .kes_sigma_i   (kes_sigma),
        .kes_tag_i     (kes_tag),
        .flush_i       (flush),
        .start_o       (start),
        .sigma_valid_o (sigma_valid),
        .sigma_low_o   (sigma_low),
        .tag_o         (tag),
        .chien_done_i  (chien_done),
        .busy_o        (busy),
        .occupancy_o   (occupancy),
        .proto_err_o   (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: FIFO of pending sigmas, plus whether the head is
    // being launched this cycle or already in Chien awaiting done.
    typedef struct {
        logic [SW-1:0]    s;
        logic [TAG_W-1:0] t;
    } ent_t;

    ent_t q[$];
    bit   m_start = 0;
    bit   m_busy  = 0;
    bit   m_err   = 0;

    task automatic model_clear();
        q.delete();
        m_start = 0;
        m_busy  = 0;
        m_err   = 0;
    endtask

    always @(negedge rst_n) model_clear();

    always @(posedge clk) begin
        bit   can_push, nstart, nbusy;
        ent_t e;
        if (!rst_n) begin
            model_clear();
        end else if (flush) begin
            model_clear();
        end else begin
            can_push = kes_valid && (q.size() < 2);
            nstart   = !m_start && !m_busy && (q.size() != 0);
            nbusy    = m_start || (m_busy && !chien_done);
            m_err    = chien_done && !m_busy;
            if (chien_done && m_busy) void'(q.pop_front());
            if (can_push) begin
                e.s = kes_sigma;
                e.t = kes_tag;
                q.push_back(e);
            end
            m_start = nstart;
            m_busy  = nbusy;
        end
    end

    task automatic chk(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic [SW-1:0]    exp_s;
        logic [TAG_W-1:0] exp_t;
        exp_s = '0;
        exp_t = '0;
        if (q.size() != 0) begin
            exp_s = q[0].s;
            exp_t = q[0].t;
        end
        chk("start",       SW'(start),       SW'(m_start));
        chk("sigma_valid", SW'(sigma_valid), SW'(m_start));
        chk("busy",        SW'(busy),        SW'(m_busy));
        chk("occupancy",   SW'(occupancy),   SW'(q.size()));
        chk("proto_err",   SW'(proto_err),   SW'(m_err));
        chk("kes_ready",   SW'(kes_ready),   SW'((q.size() < 2) && !flush));
        chk("sigma_low",   sigma_low,        exp_s);
        chk("tag",         SW'(tag),         SW'(exp_t));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [SW-1:0] rand_sigma();
        logic [SW-1:0] s;
        for (int k = 0; k <= T; k++) s[k*W +: W] = W'($urandom);
        if (s[W-1:0] == '0) s[W-1:0] = W'(1);
        return s;
    endfunction

    task automatic push(input logic [TAG_W-1:0] t);
        kes_valid = 1'b1;
        kes_sigma = rand_sigma();
        kes_tag   = t;
    endtask

    initial begin
        logic [SW-1:0] s135;
        s135 = '0;
        s135[0*W +: W] = W'(1);
        s135[1*W +: W] = W'(3);
        s135[2*W +: W] = W'(5);

        rst_n = 1'b0; kes_valid = 1'b0; kes_sigma = '0; kes_tag = '0;
        flush = 1'b0; chien_done = 1'b0;
        #2;
        chk("rst_ready", SW'(kes_ready), SW'(1));
        chk("rst_occ",   SW'(occupancy), SW'(0));
        chk("rst_start", SW'(start),     SW'(0));
        chk("rst_busy",  SW'(busy),      SW'(0));
        chk("rst_sigma", sigma_low,      SW'(0));
        step(); step();
        rst_n = 1'b1;
        step();

        // Single sigma: launch one cycle after the capturing edge, then hold.
        kes_valid = 1'b1; kes_sigma = s135; kes_tag = 4'd2;
        step();
        kes_valid = 1'b0;
        chk("t1_occ_after_push", SW'(occupancy), SW'(1));
        chk("t1_no_start_yet",   SW'(start),     SW'(0));
        step();
        chk("t1_start",      SW'(start),       SW'(1));
        chk("t1_sigma_vld",  SW'(sigma_valid), SW'(1));
        chk("t1_sigma",      sigma_low,        s135);
        chk("t1_tag",        SW'(tag),         SW'(2));
        step();
        chk("t1_start_once", SW'(start),       SW'(0));
        chk("t1_busy",       SW'(busy),        SW'(1));
        chk("t1_sigma_hold", sigma_low,        s135);
        step();
        chien_done = 1'b1;
        step();
        chien_done = 1'b0;
        chk("t1_occ_done",   SW'(occupancy), SW'(0));
        chk("t1_sigma_zero", sigma_low,      SW'(0));
        step();

        // Fill and backpressure.
        push(4'd1); step();
        push(4'd2); step();
        push(4'd3);
        chk("t2_ready_full", SW'(kes_ready), SW'(0));
        step();
        chk("t2_head1", SW'(tag), SW'(1));
        chien_done = 1'b1; step();
        chien_done = 1'b0;
        chk("t2_occ_after_pop", SW'(occupancy), SW'(1));
        step();
        kes_valid = 1'b0;
        chk("t2_start2", SW'(start), SW'(1));
        chk("t2_tag2",   SW'(tag),   SW'(2));
        chk("t2_occ2",   SW'(occupancy), SW'(2));
        step();
        chien_done = 1'b1; step();
        chien_done = 1'b0;
        chk("t2_idle_gap", SW'(start), SW'(0));
        step();
        chk("t2_start3", SW'(start), SW'(1));
        chk("t2_tag3",   SW'(tag),   SW'(3));
        step();
        chien_done = 1'b1; step();
        chien_done = 1'b0;
        step();

        // Push and pop in the same cycle.
        push(4'd5); step();
        kes_valid = 1'b0; step(); step();
        push(4'd7); chien_done = 1'b1; step();
        kes_valid = 1'b0; chien_done = 1'b0;
        chk("t3_occ_same", SW'(occupancy), SW'(1));
        step();
        chk("t3_start7", SW'(start), SW'(1));
        chk("t3_tag7",   SW'(tag),   SW'(7));
        step();
        chien_done = 1'b1; step();
        chien_done = 1'b0; step();

        // Spurious done while idle and empty.
        chien_done = 1'b1; step();
        chien_done = 1'b0;
        chk("t4_err",   SW'(proto_err), SW'(1));
        chk("t4_occ",   SW'(occupancy), SW'(0));
        step();
        chk("t4_err_once", SW'(proto_err), SW'(0));
        chk("t4_nostart",  SW'(start),     SW'(0));

        // Flush in WAIT with two entries and a push attempt.
        push(4'd8); step();
        push(4'd9); step();
        kes_valid = 1'b0; step();
        push(4'd10); flush = 1'b1; chien_done = 1'b1;
        chk("t5_ready_flush", SW'(kes_ready), SW'(0));
        step();
        kes_valid = 1'b0; flush = 1'b0; chien_done = 1'b0;
        chk("t5_occ",   SW'(occupancy), SW'(0));
        chk("t5_busy",  SW'(busy),      SW'(0));
        chk("t5_noerr", SW'(proto_err), SW'(0));
        step(); step();
        chk("t5_nostart", SW'(start), SW'(0));

        // Asynchronous reset in WAIT.
        push(4'd4); step();
        kes_valid = 1'b0; step(); step();
        chk("t6_busy_pre", SW'(busy), SW'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("t6_busy",  SW'(busy),      SW'(0));
        chk("t6_start", SW'(start),     SW'(0));
        chk("t6_occ",   SW'(occupancy), SW'(0));
        chk("t6_ready", SW'(kes_ready), SW'(1));
        step();
        rst_n = 1'b1;
        step(); step();
        chk("t6_nostart", SW'(start), SW'(0));

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            kes_valid  = 1'($urandom_range(0, 1));
            kes_sigma  = rand_sigma();
            kes_tag    = TAG_W'($urandom);
            chien_done = ($urandom_range(0, 2) == 0);
            flush      = ($urandom_range(0, 39) == 0);
            step();
        end
        kes_valid = 1'b0; chien_done = 1'b0; flush = 1'b0;
        step(); step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
